// File: rtl/vga_timing.sv
// Video timing generator: pixel clock-enable divider, PIX/LINE counters and
// registered HSYNC/VSYNC/BLANK/FRAME aligned with the image source RGB register.
module vga_timing #(
  parameter int unsigned CE_DIV   = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       CE,
  output logic [9:0] PIX,
  output logic [9:0] LINE,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       BLANK,
  output logic       FRAME
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CE_DIV < 1) begin : g_param_err
    $error("vga_timing: H_TOTAL/V_TOTAL must be <= 1024 and CE_DIV >= 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             ce_q, ce_d;
  logic [9:0]       pix_q, pix_d;
  logic [9:0]       line_q, line_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             blank_q, blank_d;
  logic             frame_q, frame_d;
  logic [10:0]      pix_x, line_x;

  // Widened copies so range limits up to 1024 compare without truncation.
  assign pix_x  = {1'b0, pix_q};
  assign line_x = {1'b0, line_q};

  // Next state: divider always runs; counters and decode advance only on CE.
  always_comb begin
    ce_d    = (div_q == DIV_W'(CE_DIV - 1));
    div_d   = ce_d ? '0 : div_q + DIV_W'(1);
    pix_d   = pix_q;
    line_d  = line_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    blank_d = blank_q;
    frame_d = 1'b0;
    if (ce_q) begin
      hsync_d = (pix_x >= 11'(HS_START) && pix_x < 11'(HS_END)) ? H_POL : ~H_POL;
      vsync_d = (line_x >= 11'(VS_START) && line_x < 11'(VS_END)) ? V_POL : ~V_POL;
      blank_d = (pix_x >= 11'(H_ACTIVE)) || (line_x >= 11'(V_ACTIVE));
      if (pix_q == 10'(H_TOTAL - 1)) begin
        pix_d   = '0;
        frame_d = (line_q == 10'(V_TOTAL - 1));
        line_d  = frame_d ? '0 : line_q + 10'd1;
      end else begin
        pix_d = pix_q + 10'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q   <= '0;
      ce_q    <= 1'b0;
      pix_q   <= '0;
      line_q  <= '0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      ce_q    <= ce_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      frame_q <= frame_d;
    end
  end

  assign CE    = ce_q;
  assign PIX   = pix_q;
  assign LINE  = line_q;
  assign HSYNC = hsync_q;
  assign VSYNC = vsync_q;
  assign BLANK = blank_q;
  assign FRAME = frame_q;

endmodule
